uart_rx_deframer: RTL and testbench

Receive-side framing stage placed directly downstream of the `uart` byte receiver. It consumes the raw byte stream on the UART's `m_axis` output. It hunts for a sync byte, reads a length byte, buffers the payload and checks an 8-bit additive checksum. Only verified payloads are re-emitted as an AXI-stream packet with `tlast`; corrupted or malformed frames are dropped and reported.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_frame_buf.sv | 37 +++
 rtl/uart_rx_deframer.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive-side deframer.
package uart_pkg;

    // Deframer FSM states
    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        EMIT
    } deframer_state_e;

    // Cause of the most recent dropped frame, as seen on err_code
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } deframer_err_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // 8-bit additive checksum step; wraps mod 256
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload buffer, one write port and one
// registered read port. rd_data only changes when rd_en is high, so the
// read data doubles as the stalled output beat of the deframer.
module uart_frame_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 64,
    parameter int PTR_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MAX_LEN];

    // Storage array: no reset, contents are only meaningful after PAYLOAD
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value while rd_en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: hunts for SYNC_BYTE, reads LEN, buffers LEN payload
// bytes, verifies CSUM = (LEN + sum(payload)) mod 256, and replays only
// verified payloads on m_axis with tlast. Bad frames are dropped and flagged.
// Optional inter-byte timeout: define DEFRAMER_TIMEOUT_EN.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code
);

    localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    generate
        if (DATA_WIDTH != 8 || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("uart_rx_deframer: unsupported parameter set");
        end
    endgenerate

    deframer_state_e state_q, state_d;
    deframer_err_e   err_q;

    logic [7:0] len_q;
    logic [7:0] acc_q;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic       frame_ok_q;
    logic       frame_err_q;

    logic             s_acc;
    logic             m_hs;
    logic             len_bad;
    logic             csum_ok;
    logic             last_pay;
    logic             last_beat;
    logic             timeout_hit;
    logic             buf_wr_en;
    logic             buf_rd_en;
    logic [PTR_W-1:0] buf_wr_addr;
    logic [PTR_W-1:0] buf_rd_addr;

    assign s_acc     = s_axis_tvalid && s_axis_tready;
    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign len_bad   = (s_axis_tdata == 8'd0) || (s_axis_tdata > MAX_LEN_B);
    assign csum_ok   = (s_axis_tdata == acc_q);
    assign last_pay  = (wr_ptr == len_q - 8'd1);
    assign last_beat = (rd_ptr == len_q - 8'd1);

`ifdef DEFRAMER_TIMEOUT_EN
    logic        in_frame;
    logic [31:0] to_cnt;

    assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);

    // Inter-byte idle counter; only runs while a frame is being collected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!in_frame || s_acc || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    assign timeout_hit = in_frame && (to_cnt >= 32'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; SYNC_BYTE mid-frame is plain data
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (s_acc && s_axis_tdata == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (timeout_hit)  state_d = HUNT;
                else if (s_acc)   state_d = len_bad ? HUNT : PAYLOAD;
            end
            PAYLOAD: begin
                if (timeout_hit)            state_d = HUNT;
                else if (s_acc && last_pay) state_d = CSUM;
            end
            CSUM: begin
                if (timeout_hit) state_d = HUNT;
                else if (s_acc)  state_d = csum_ok ? EMIT : HUNT;
            end
            EMIT: begin
                if (m_hs && last_beat) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    // FSM outputs: upstream is stalled for the whole replay
    always_comb begin
        s_axis_tready = (state_q != EMIT);
        m_axis_tvalid = (state_q == EMIT);
        m_axis_tlast  = (state_q == EMIT) && last_beat;
    end

    // Frame datapath: length, checksum accumulator, pointers, status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            acc_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                LEN: begin
                    if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_TIMEOUT;
                    end else if (s_acc) begin
                        if (len_bad) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ERR_LEN;
                        end else begin
                            len_q  <= s_axis_tdata;
                            acc_q  <= s_axis_tdata;
                            wr_ptr <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_TIMEOUT;
                    end else if (s_acc) begin
                        acc_q  <= csum_add(acc_q, s_axis_tdata);
                        wr_ptr <= wr_ptr + 8'd1;
                    end
                end
                CSUM: begin
                    if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        err_q       <= ERR_TIMEOUT;
                    end else if (s_acc) begin
                        if (csum_ok) begin
                            frame_ok_q <= 1'b1;
                            rd_ptr     <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_q       <= ERR_CSUM;
                        end
                    end
                end
                EMIT: begin
                    if (m_hs) rd_ptr <= rd_ptr + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Buffer control: byte 0 is prefetched on the passing CSUM byte so it is
    // on m_axis the next cycle; afterwards each handshake fetches the next.
    always_comb begin
        buf_wr_en   = (state_q == PAYLOAD) && s_acc && !timeout_hit;
        buf_wr_addr = PTR_W'(wr_ptr);
        buf_rd_en   = ((state_q == CSUM) && s_acc && csum_ok && !timeout_hit) ||
                      ((state_q == EMIT) && m_hs && !last_beat);
        buf_rd_addr = (state_q == CSUM) ? '0 : PTR_W'(rd_ptr + 8'd1);
    end

    uart_frame_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_LEN   (MAX_LEN),
        .PTR_W     (PTR_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (buf_wr_en),
        .wr_addr(buf_wr_addr),
        .wr_data(s_axis_tdata),
        .rd_en  (buf_rd_en),
        .rd_addr(buf_rd_addr),
        .rd_data(m_axis_tdata)
    );

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames against a stream-scanning model.
// Timeout scenario is included when DEFRAMER_TIMEOUT_EN is defined.
module tb_uart_rx_deframer;

    localparam int MAX_LEN = 64;
    localparam int TO_CYC  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_rx_deframer #(
        .DATA_WIDTH    (8),
        .MAX_LEN       (MAX_LEN),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    int         exp_ev[$];   // 0 = frame_ok, else the expected err_code
    int         exp_err = 0;
    logic [7:0] got[$];
    logic [7:0] vec[$];
    logic       bp_mode = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Model: scan a byte stream for complete frames and derive outputs
    task automatic model_scan(input logic [7:0] v[$]);
        int i, n, len, sum;
        i = 0;
        n = v.size();
        while (i < n) begin
            if (v[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            len = int'(v[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                exp_ev.push_back(1);
                i += 2;
                continue;
            end
            if (i + 2 + len >= n) break;
            sum = len;
            for (int k = 0; k < len; k++) sum += int'(v[i+2+k]);
            if ((sum % 256) == int'(v[i+2+len])) begin
                exp_ev.push_back(0);
                for (int k = 0; k < len; k++) begin
                    exp_data.push_back(v[i+2+k]);
                    exp_last.push_back(k == len - 1);
                end
            end else begin
                exp_ev.push_back(2);
            end
            i += 3 + len;
        end
    endtask

    // Downstream ready: steady high, or toggling every cycle under backpressure
    always @(posedge clk) begin
        #2;
        m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
    end

    // Per-cycle compare against the model
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    logic       prev_ok = 1'b0;
    logic       prev_err = 1'b0;
    int         ev_v;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_ok    = 1'b0;
            prev_err   = 1'b0;
        end else begin
            chk("tready_vs_valid", s_axis_tready, !m_axis_tvalid);
            if (prev_stall) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, prev_d);
                chk("stall_last", m_axis_tlast, prev_l);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_beat", m_axis_tdata, 256);
                end else begin
                    chk("beat_data", m_axis_tdata, exp_data.pop_front());
                    chk("beat_last", m_axis_tlast, exp_last.pop_front());
                end
                got.push_back(m_axis_tdata);
            end
            if (prev_ok)  chk("ok_pulse_width", frame_ok, 0);
            if (prev_err) chk("err_pulse_width", frame_err, 0);
            if (frame_ok || frame_err) begin
                chk("ok_err_exclusive", frame_ok && frame_err, 0);
                if (exp_ev.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    ev_v = exp_ev.pop_front();
                    chk("event_kind", frame_err, ev_v != 0);
                    if (frame_err) exp_err = ev_v;
                end
            end
            chk("err_code", err_code, exp_err);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
            prev_ok    = frame_ok;
            prev_err   = frame_err;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!s_axis_tready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [7:0] v[$]);
        model_scan(v);
        foreach (v[i]) send_byte(v[i]);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_data.size() != 0 || exp_ev.size() != 0) && g < 500) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            g++;
        end
        chk("drain_timeout", exp_data.size() + exp_ev.size(), 0);
        repeat (3) @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 1);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Good 3-byte frame; beat 0 appears the cycle after CSUM
        got.delete();
        vec = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_vec(vec);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("a_ok_n1", frame_ok, 1);
        chk("a_valid_n1", m_axis_tvalid, 1);
        chk("a_data_n1", m_axis_tdata, 8'h11);
        drain();
        chk("a_count", got.size(), 3);
        chk("a_b0", got[0], 8'h11);
        chk("a_b1", got[1], 8'h22);
        chk("a_b2", got[2], 8'h33);
        chk("a_err_code", err_code, 0);

        // Checksum error, then a good 1-byte frame
        got.delete();
        vec = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_vec(vec);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("b_err_n1", frame_err, 1);
        chk("b_code_n1", err_code, 2);
        chk("b_no_valid", m_axis_tvalid, 0);
        vec = {8'hA5, 8'h01, 8'h7F, 8'h80};
        send_vec(vec);
        drain();
        chk("b_count", got.size(), 1);
        chk("b_b0", got[0], 8'h7F);
        chk("b_err_hold", err_code, 2);

        // Bad lengths: zero and MAX_LEN+1
        got.delete();
        vec = {8'hA5, 8'h00};
        send_vec(vec);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("c0_err_n1", frame_err, 1);
        chk("c0_code", err_code, 1);
        chk("c0_hunt", s_axis_tready, 1);
        vec = {8'hA5, 8'h41};
        send_vec(vec);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("c41_err_n1", frame_err, 1);
        chk("c41_code", err_code, 1);
        vec = {8'hA5, 8'h01, 8'h05, 8'h06};
        send_vec(vec);
        drain();
        chk("c_count", got.size(), 1);
        chk("c_b0", got[0], 8'h05);

        // Garbage before sync, sync value inside payload
        got.delete();
        vec = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
        send_vec(vec);
        drain();
        chk("d_count", got.size(), 2);
        chk("d_b0", got[0], 8'hA5);
        chk("d_b1", got[1], 8'hA5);

        // Maximum-length frame
        got.delete();
        vec.delete();
        vec.push_back(8'hA5);
        vec.push_back(8'(MAX_LEN));
        for (int k = 0; k < MAX_LEN; k++) vec.push_back(8'(k));
        vec.push_back(8'h20);
        send_vec(vec);
        drain();
        chk("max_count", got.size(), MAX_LEN);

        // Backpressure, with the next frame queued behind EMIT
        got.delete();
        bp_mode = 1'b1;
        vec = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_vec(vec);
        vec = {8'hA5, 8'h01, 8'h05, 8'h06};
        send_vec(vec);
        drain();
        bp_mode = 1'b0;
        chk("bp_count", got.size(), 4);
        chk("bp_b0", got[0], 8'h11);
        chk("bp_b1", got[1], 8'h22);
        chk("bp_b2", got[2], 8'h33);
        chk("bp_b3", got[3], 8'h05);

`ifdef DEFRAMER_TIMEOUT_EN
        // Stall mid-payload past the timeout
        got.delete();
        vec = {8'hA5, 8'h03, 8'h11};
        send_vec(vec);
        exp_ev.push_back(3);
        drain();
        chk("to_code", err_code, 3);
        chk("to_no_beats", got.size(), 0);
`endif

        // Reset mid-payload aborts silently
        got.delete();
        vec = {8'hA5, 8'h03, 8'h11};
        send_vec(vec);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        exp_err = 0;
        #1;
        chk("mid_rst_s_tready", s_axis_tready, 1);
        chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_frame_ok", frame_ok, 0);
        chk("mid_rst_err_code", err_code, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec = {8'hA5, 8'h01, 8'h05, 8'h06};
        send_vec(vec);
        drain();
        chk("post_rst_count", got.size(), 1);
        chk("post_rst_b0", got[0], 8'h05);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
